conv_accumulator: RTL and testbench
===================================

CONV_ACCUMULATOR -- requirements
Module: conv_accumulator

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port i_start, input, 1 bit: single-cycle request to begin one convolution window.
REQ-004 SHALL have port i_depth, input, 2 bits: channel depth sampled with i_start; 0=8, 1=16, 2=32, 3=32.
REQ-005 SHALL have port o_in_ready, output, 1 bit: high while the block accepts pixels.
REQ-006 SHALL have port i_pix_valid, input, 1 bit: pixel strobe; a pixel is accepted on an edge where i_pix_valid and o_in_ready are both high.
REQ-007 SHALL have port i_pix_data, input, 8 bits: unsigned pixel; upstream supplies 0 for out-of-image positions.
REQ-008 SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port o_out_valid, output, 1 bit: o_out_data holds a result.
REQ-010 SHALL have port o_out_data, output, 14 bits: unsigned rounded convolution result.

Function
REQ-011 SHALL implement states IDLE, ACCUM, ROUND and OUT.
- IDLE->ACCUM: on i_start.
- ACCUM->ROUND: on acceptance of the last pixel.
- ROUND->OUT: unconditional.
- OUT->IDLE: after the 4th result.
REQ-012 SHALL, on the edge accepting i_start in IDLE, latch i_depth, clear all four accumulators and clear the pixel index and channel counters.
REQ-013 SHALL ignore i_start outside IDLE, and ignore i_pix_valid outside ACCUM.
REQ-014 SHALL drive o_in_ready high exactly in ACCUM.
REQ-015 SHALL accept pixels in this order: per channel, 16 pixels of a 4x4 window in row-major order (r=0..3, c=0..3); channels follow consecutively; the total is 16*D pixels.
REQ-016 SHALL tolerate arbitrary gaps (i_pix_valid low) in ACCUM, holding all counters and accumulators.
REQ-017 SHALL maintain a 4-bit pixel index that wraps 15->0 and increments the 5-bit channel counter on wrap.
- The last pixel is index 15 with channel = D-1.
REQ-018 SHALL keep four 17-bit accumulators A0..A3 for outputs at window positions (1,1), (1,2), (2,1), (2,2).
REQ-019 SHALL, for each accepted pixel at (r,c) and each output at (orow,ocol), compute dr=r-orow and dc=c-ocol.
- If |dr|<=1 and |dc|<=1: add pixel*w, where w=(dr==0?2:1)*(dc==0?2:1) (weights 1/2/4).
- Otherwise: add nothing.
REQ-020 SHALL update all four accumulators in the same cycle the pixel is accepted (no internal buffering of pixels).
REQ-021 SHALL compute each result as (A+8)>>4, round half up.
- Maximum value is 8160; no saturation is needed.
REQ-022 SHALL meet this output timing, where E is the edge accepting the last pixel:
- E+1: state ROUND.
- E+2..E+5: o_out_valid high, presenting A0, A1, A2, A3 in that order, one per cycle.
- E+6: o_out_valid low and state IDLE.
REQ-023 SHALL have no output backpressure; results are not held.
REQ-024 SHALL drive o_out_data to 0 whenever o_out_valid is low.
REQ-025 SHALL allow a new i_start to be accepted at the earliest on edge E+6, when o_busy is low.

Reset
REQ-026 SHALL, while i_rst_n is low, force:
- state IDLE;
- o_in_ready=0, o_busy=0, o_out_valid=0, o_out_data=0;
- accumulators, counters and the latched depth to 0.
REQ-027 SHALL, on reset asserted mid-ACCUM or mid-OUT, abandon the window: no further outputs; the next window requires a new i_start.

Verification
REQ-028 SHALL pass: depth=2, all 512 pixels 255 -> four outputs of 8160 on consecutive cycles starting at E+2.
REQ-029 SHALL pass: depth=0, all 128 pixels 1 -> four outputs of 8.
REQ-030 SHALL pass: depth=0, only channel 0 pixel (0,0)=16, rest 0 -> outputs 1, 0, 0, 0.
REQ-031 SHALL pass: depth=0, only channel 0 pixel (1,1)=2 -> A=8,4,4,2 -> outputs 1, 0, 0, 0 (rounding check).
REQ-032 SHALL pass: depth=1, random gaps in i_pix_valid, plus i_start pulsed during ACCUM -> results identical to gap-free run; the extra i_start is ignored.
REQ-033 SHALL pass: reset asserted after 40 pixels -> all outputs 0 immediately; a fresh depth=0 all-ones window then yields 8, 8, 8, 8.

Source files
------------

// File: rtl/conv_accumulator_if.sv
// conv_accumulator_if
//
// Bundles the pixel-in / result-out signals of conv_accumulator.
//
// Handshake rules:
//   - A pixel transfers on a rising edge where i_pix_valid and o_in_ready
//     are both high.
//   - o_out_valid has no ready: each result is presented for exactly one
//     cycle and is not held.
//   - i_start is a single-cycle request that only matters while o_busy is
//     low.
//
// Signals:
//   i_start     : request to begin one convolution window
//   i_depth     : channel depth code sampled with i_start (0=8, 1=16, 2/3=32)
//   o_in_ready  : block accepts pixels
//   i_pix_valid : pixel strobe
//   i_pix_data  : unsigned 8-bit pixel
//   o_busy      : block is not idle
//   o_out_valid : o_out_data holds a result
//   o_out_data  : rounded 14-bit result
//
// Modports:
//   slave  : the accumulator itself
//   master : the pixel source / result sink
interface conv_accumulator_if;
    logic        i_start;
    logic [1:0]  i_depth;
    logic        o_in_ready;
    logic        i_pix_valid;
    logic [7:0]  i_pix_data;
    logic        o_busy;
    logic        o_out_valid;
    logic [13:0] o_out_data;

    modport slave (
        input  i_start,
        input  i_depth,
        input  i_pix_valid,
        input  i_pix_data,
        output o_in_ready,
        output o_busy,
        output o_out_valid,
        output o_out_data
    );

    modport master (
        output i_start,
        output i_depth,
        output i_pix_valid,
        output i_pix_data,
        input  o_in_ready,
        input  o_busy,
        input  o_out_valid,
        input  o_out_data
    );
endinterface

// File: rtl/conv_accumulator.sv
// conv_accumulator
//
// Streams a 4x4 pixel window per channel, D channels back to back, and
// accumulates four 3x3 weighted sums (kernel 1 2 1 / 2 4 2 / 1 2 1) for the
// centre positions (1,1), (1,2), (2,1) and (2,2) of the window. Every pixel
// is folded into all four accumulators in the cycle it is accepted, so no
// pixel storage is needed. After the last pixel the four sums are rounded
// ((A+8)>>4) and presented one per cycle.
//
// Timing, with E the edge accepting the last pixel:
//   after E     : ROUND
//   after E+1.. : OUT, results A0, A1, A2, A3 on four consecutive cycles
//   after E+5   : IDLE, o_busy low, ready for the next i_start
//
// Ports:
//   i_clk       : clock, rising edge
//   i_rst_n     : asynchronous active-low reset
//   bus         : conv_accumulator_if.slave (start, pixel and result signals)
//   o_dbg_state : current FSM state (0=IDLE, 1=ACCUM, 2=ROUND, 3=OUT)
module conv_accumulator (
    input  logic                i_clk,
    input  logic                i_rst_n,
    conv_accumulator_if.slave   bus,
    output logic [1:0]          o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_ROUND = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  depth_q;
    logic [3:0]  pix_idx;      // row-major position inside the 4x4 window
    logic [4:0]  chan_cnt;     // channel currently being streamed
    logic [1:0]  out_sel;      // which accumulator is on o_out_data
    logic [16:0] acc [4];

    logic        in_ready_q;
    logic        busy_q;
    logic        out_valid_q;
    logic [13:0] out_data_q;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // One-dimensional kernel tap: 2 on the centre, 1 on a neighbour,
    // 0 further away. p is the pixel coordinate, o the output coordinate
    // (always 1 or 2, so o+1 never wraps).
    function automatic logic [1:0] axis_w(input logic [1:0] p, input logic [1:0] o);
        logic [2:0] pe;
        logic [2:0] oe;
        pe = {1'b0, p};
        oe = {1'b0, o};
        if (pe == oe)
            return 2'd2;
        else if ((pe + 3'd1 == oe) || (pe == oe + 3'd1))
            return 2'd1;
        else
            return 2'd0;
    endfunction

    // Round half up and drop four fraction bits. A is at most 130560, so
    // A+8 stays inside 17 bits and the result fits in 13 bits.
    function automatic logic [13:0] round_acc(input logic [16:0] a);
        logic [16:0] t;
        t = a + 17'd8;
        return {1'b0, t[16:4]};
    endfunction

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------

    logic [4:0]  last_chan;
    logic        accept;
    logic        last_pix;
    logic [1:0]  pix_r;
    logic [1:0]  pix_c;
    logic [2:0]  tap_w   [4];
    logic [16:0] contrib [4];
    logic [1:0]  next_sel;

    always_comb begin
        last_chan = 5'd0;
        case (depth_q)
            2'd0:    last_chan = 5'd7;
            2'd1:    last_chan = 5'd15;
            default: last_chan = 5'd31;
        endcase
    end

    // o_in_ready is registered high exactly in ACCUM, so the transfer
    // condition alone qualifies accumulation.
    assign accept   = bus.i_pix_valid && in_ready_q;
    assign last_pix = accept && (pix_idx == 4'd15) && (chan_cnt == last_chan);
    assign pix_r    = pix_idx[3:2];
    assign pix_c    = pix_idx[1:0];
    assign next_sel = out_sel + 2'd1;

    // Accumulator k sits at row 1+k[1], column 1+k[0]. The 2-D weight is
    // the product of the two axis taps, giving 0, 1, 2 or 4.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            logic [1:0] orow;
            logic [1:0] ocol;
            orow       = (k >= 2) ? 2'd2 : 2'd1;
            ocol       = (k % 2 == 1) ? 2'd2 : 2'd1;
            tap_w[k]   = {1'b0, axis_w(pix_r, orow)} * {1'b0, axis_w(pix_c, ocol)};
            contrib[k] = {9'd0, bus.i_pix_data} * {14'd0, tap_w[k]};
        end
    end

    // ------------------------------------------------------------------
    // FSM, counters, accumulators and registered outputs
    // ------------------------------------------------------------------

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            depth_q     <= 2'd0;
            pix_idx     <= 4'd0;
            chan_cnt    <= 5'd0;
            out_sel     <= 2'd0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 14'd0;
            for (int k = 0; k < 4; k++)
                acc[k] <= 17'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        state      <= S_ACCUM;
                        depth_q    <= bus.i_depth;
                        pix_idx    <= 4'd0;
                        chan_cnt   <= 5'd0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        for (int k = 0; k < 4; k++)
                            acc[k] <= 17'd0;
                    end
                end

                // Gaps (i_pix_valid low) simply hold everything.
                S_ACCUM: begin
                    if (accept) begin
                        for (int k = 0; k < 4; k++)
                            acc[k] <= acc[k] + contrib[k];
                        pix_idx <= pix_idx + 4'd1;
                        if (pix_idx == 4'd15)
                            chan_cnt <= chan_cnt + 5'd1;
                        if (last_pix) begin
                            state      <= S_ROUND;
                            in_ready_q <= 1'b0;
                        end
                    end
                end

                // Accumulators are frozen from here on; the first result
                // is launched while leaving ROUND.
                S_ROUND: begin
                    state       <= S_OUT;
                    out_sel     <= 2'd0;
                    out_valid_q <= 1'b1;
                    out_data_q  <= round_acc(acc[0]);
                end

                S_OUT: begin
                    if (out_sel == 2'd3) begin
                        state       <= S_IDLE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                        out_data_q  <= 14'd0;
                    end else begin
                        out_sel    <= next_sel;
                        out_data_q <= round_acc(acc[next_sel]);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_in_ready  = in_ready_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_out_valid = out_valid_q;
    assign bus.o_out_data  = out_data_q;
    assign o_dbg_state     = state;

endmodule

// File: tb/tb_conv_accumulator.sv
// tb_conv_accumulator
//
// Directed bench for conv_accumulator. A table of windows (depth, pixel
// pattern, expected four results) is streamed through the block, each
// window starting on the first edge that o_busy is low after the previous
// one. Hand-written sequences cover reset mid-ACCUM and mid-OUT.
module tb_conv_accumulator;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    conv_accumulator_if bus ();

    conv_accumulator dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    logic [13:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (called just after a rising edge)
    // ------------------------------------------------------------------
    task automatic start_window(input logic [1:0] d);
        bus.i_start = 1'b1;
        bus.i_depth = d;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        bus.i_depth = d ^ 2'b01;   // depth must have been latched
        chk("start_ready", bus.o_in_ready, 1);
        chk("start_busy", bus.o_busy, 1);
    endtask

    task automatic send_pixel(input logic [7:0] v);
        int t;
        bus.i_pix_valid = 1'b1;
        bus.i_pix_data  = v;
        t = 0;
        while (!bus.o_in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.o_in_ready) begin
            checks++;
            errors++;
            $display("FAIL pix_ready_timeout actual=0 expected=1 at %0t", $time);
        end
        @(posedge clk); #1;
    endtask

    // Called just after edge E; pops four expected results from exp_q.
    task automatic check_window(input string name);
        logic [13:0] e;
        @(negedge clk);
        chk({name, "_round_valid"}, bus.o_out_valid, 0);
        chk({name, "_round_ready"}, bus.o_in_ready, 0);
        chk({name, "_round_busy"}, bus.o_busy, 1);
        chk({name, "_round_state"}, dbg_state, 2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk({name, "_out_valid"}, bus.o_out_valid, 1);
            chk({name, "_out_data"}, bus.o_out_data, e);
        end
        @(negedge clk);
        chk({name, "_end_valid"}, bus.o_out_valid, 0);
        chk({name, "_end_data"}, bus.o_out_data, 0);
        chk({name, "_end_busy"}, bus.o_busy, 0);
        chk({name, "_end_state"}, dbg_state, 0);
    endtask

    task automatic push_exp(input logic [13:0] a, input logic [13:0] b,
                            input logic [13:0] c, input logic [13:0] d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    task automatic run_ones_d0();
        start_window(2'd0);
        for (int i = 0; i < 128; i++)
            send_pixel(8'd1);
        bus.i_pix_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        string       name;
        logic [1:0]  depth;
        logic [7:0]  fill;
        logic        spot_en;
        logic [4:0]  spot_ch;
        logic [3:0]  spot_idx;
        logic [7:0]  spot_val;
        logic        gaps;      // random idle cycles plus a stray i_start
        logic        junk;      // keep i_pix_valid high after the last pixel
        logic [13:0] e0, e1, e2, e3;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        int nch;
        int n;
        logic [7:0] v;

        vecs[0]  = '{"all255_d2",  2'd2, 8'd255, 1'b0, 5'd0,  4'd0,  8'd0,   1'b0, 1'b0, 14'd8160, 14'd8160, 14'd8160, 14'd8160};
        vecs[1]  = '{"ones_d0",    2'd0, 8'd1,   1'b0, 5'd0,  4'd0,  8'd0,   1'b0, 1'b0, 14'd8,  14'd8,  14'd8,  14'd8};
        vecs[2]  = '{"spot00_d0",  2'd0, 8'd0,   1'b1, 5'd0,  4'd0,  8'd16,  1'b0, 1'b0, 14'd1,  14'd0,  14'd0,  14'd0};
        vecs[3]  = '{"spot11_d0",  2'd0, 8'd0,   1'b1, 5'd0,  4'd5,  8'd2,   1'b0, 1'b0, 14'd1,  14'd0,  14'd0,  14'd0};
        vecs[4]  = '{"spot22_d1",  2'd1, 8'd0,   1'b1, 5'd0,  4'd10, 8'd100, 1'b0, 1'b0, 14'd6,  14'd13, 14'd13, 14'd25};
        vecs[5]  = '{"spot03_d0",  2'd0, 8'd0,   1'b1, 5'd7,  4'd3,  8'd32,  1'b0, 1'b0, 14'd0,  14'd2,  14'd0,  14'd0};
        vecs[6]  = '{"spot33_d1",  2'd1, 8'd0,   1'b1, 5'd15, 4'd15, 8'd200, 1'b0, 1'b0, 14'd0,  14'd0,  14'd0,  14'd13};
        vecs[7]  = '{"spot01_d0",  2'd0, 8'd0,   1'b1, 5'd2,  4'd1,  8'd7,   1'b0, 1'b0, 14'd1,  14'd0,  14'd0,  14'd0};
        vecs[8]  = '{"threes_gap", 2'd1, 8'd3,   1'b0, 5'd0,  4'd0,  8'd0,   1'b1, 1'b1, 14'd48, 14'd48, 14'd48, 14'd48};
        vecs[9]  = '{"threes_d1",  2'd1, 8'd3,   1'b0, 5'd0,  4'd0,  8'd0,   1'b0, 1'b0, 14'd48, 14'd48, 14'd48, 14'd48};
        vecs[10] = '{"ones_d3",    2'd3, 8'd1,   1'b0, 5'd0,  4'd0,  8'd0,   1'b0, 1'b0, 14'd32, 14'd32, 14'd32, 14'd32};

        // Reset
        rst_n           = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_depth     = 2'd0;
        bus.i_pix_valid = 1'b0;
        bus.i_pix_data  = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.o_in_ready, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_valid", bus.o_out_valid, 0);
        chk("rst_data", bus.o_out_data, 0);
        chk("rst_state", dbg_state, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Pixels offered while idle must be ignored
        bus.i_pix_valid = 1'b1;
        bus.i_pix_data  = 8'd200;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_pix_ready", bus.o_in_ready, 0);
        chk("idle_pix_busy", bus.o_busy, 0);
        bus.i_pix_valid = 1'b0;

        // Table-driven windows, back to back
        for (int vi = 0; vi < NV; vi++) begin
            nch = (vecs[vi].depth == 2'd0) ? 8 : (vecs[vi].depth == 2'd1) ? 16 : 32;
            push_exp(vecs[vi].e0, vecs[vi].e1, vecs[vi].e2, vecs[vi].e3);
            start_window(vecs[vi].depth);
            for (int ch = 0; ch < nch; ch++) begin
                for (int ix = 0; ix < 16; ix++) begin
                    v = (vecs[vi].spot_en && ch == int'(vecs[vi].spot_ch) && ix == int'(vecs[vi].spot_idx))
                        ? vecs[vi].spot_val : vecs[vi].fill;
                    if (vecs[vi].gaps) begin
                        bus.i_pix_valid = 1'b0;
                        n = $urandom_range(0, 3);
                        repeat (n) begin
                            @(posedge clk); #1;
                        end
                        if (ch == 3 && ix == 0) begin
                            bus.i_start = 1'b1;
                            bus.i_depth = 2'd0;
                            @(posedge clk); #1;
                            bus.i_start = 1'b0;
                        end
                    end
                    send_pixel(v);
                end
            end
            if (vecs[vi].junk)
                bus.i_pix_data = 8'd255;
            else
                bus.i_pix_valid = 1'b0;
            check_window(vecs[vi].name);
            bus.i_pix_valid = 1'b0;
        end

        // Reset after 40 pixels of an ACCUM window
        @(posedge clk); #1;
        start_window(2'd0);
        for (int i = 0; i < 40; i++)
            send_pixel(8'd1);
        bus.i_pix_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_accum_rst_ready", bus.o_in_ready, 0);
        chk("mid_accum_rst_busy", bus.o_busy, 0);
        chk("mid_accum_rst_valid", bus.o_out_valid, 0);
        chk("mid_accum_rst_data", bus.o_out_data, 0);
        chk("mid_accum_rst_state", dbg_state, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.i_pix_valid = 1'b1;
        bus.i_pix_data  = 8'd1;
        repeat (4) begin
            @(negedge clk);
            chk("after_rst_ready", bus.o_in_ready, 0);
            chk("after_rst_valid", bus.o_out_valid, 0);
        end
        bus.i_pix_valid = 1'b0;
        @(posedge clk); #1;
        push_exp(14'd8, 14'd8, 14'd8, 14'd8);
        run_ones_d0();
        check_window("fresh_ones_d0");

        // Reset in the middle of OUT: no further results
        @(posedge clk); #1;
        run_ones_d0();
        @(negedge clk);
        @(negedge clk);
        chk("mid_out_first_valid", bus.o_out_valid, 1);
        chk("mid_out_first_data", bus.o_out_data, 8);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_out_rst_valid", bus.o_out_valid, 0);
        chk("mid_out_rst_data", bus.o_out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("mid_out_after_valid", bus.o_out_valid, 0);
            chk("mid_out_after_busy", bus.o_busy, 0);
        end

        chk("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
